// File: rtl/core_pkg.sv
// Types and constants shared by the fetch stage and the stages downstream of IF/ID.
package core_pkg;

    localparam int          XLEN      = 64;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. A bubble outranks a hold so that a flush is never lost under a stall.
module if_id_reg
    import core_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_hold,
    input  logic   i_bubble,
    input  if_id_t i_d,
    output if_id_t o_q
);

    if_id_t r_q;

    // On a bubble the pc field keeps its last value; consumers qualify it with valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q.valid <= 1'b0;
            r_q.pc    <= '0;
            r_q.instr <= NOP_INSTR;
        end else if (i_bubble) begin
            r_q.valid <= 1'b0;
            r_q.instr <= NOP_INSTR;
        end else if (!i_hold) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the zero-latency instruction memory and fills IF/ID.
// Misaligned redirects and out-of-range PCs park the stage in a sticky FAULT state until reset.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              MEM_BYTES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_adr,
    input  logic [31:0]     imem_instr,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_addr,
    output logic [31:0]     fetch_count
);

    localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_BYTES - 4);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] r_fault_addr;
    logic [XLEN-1:0] w_fault_addr_next;
    logic [31:0]     r_count;
    logic [31:0]     w_count_next;
    logic            r_fetch_fault;
    logic            w_hold;
    logic            w_bubble;
    if_id_t          w_ifid_d;
    if_id_t          w_ifid_q;

    assign w_ifid_d = '{valid: 1'b1, pc: r_pc, instr: imem_instr};

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_fault_addr_next = r_fault_addr;
        w_count_next      = r_count;
        w_hold            = 1'b1;
        w_bubble          = 1'b0;
        unique case (r_state)
            RUN: begin
                if (redirect_valid) begin
                    w_bubble = 1'b1;
                    if (redirect_target[1:0] != 2'b00) begin
                        w_state_next      = FAULT;
                        w_fault_addr_next = redirect_target;
                    end else begin
                        w_pc_next = redirect_target;
                    end
                end else if (stall) begin
                    w_hold = 1'b1;
                end else if (r_pc > LAST_PC) begin
                    // Redirect targets are only range-checked here, on their first fetch.
                    w_state_next      = FAULT;
                    w_fault_addr_next = r_pc;
                    w_bubble          = 1'b1;
                end else begin
                    w_hold       = 1'b0;
                    w_pc_next    = r_pc + XLEN'(4);
                    w_count_next = r_count + 32'd1;
                end
            end
            FAULT: begin
                w_bubble = 1'b1;
            end
            default: begin
                w_state_next = FAULT;
                w_bubble     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_fault_addr  <= '0;
            r_count       <= '0;
            r_fetch_fault <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_fault_addr  <= w_fault_addr_next;
            r_count       <= w_count_next;
            r_fetch_fault <= (w_state_next == FAULT);
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_hold   (w_hold),
        .i_bubble (w_bubble),
        .i_d      (w_ifid_d),
        .o_q      (w_ifid_q)
    );

    assign imem_adr    = r_pc;
    assign if_id_valid = w_ifid_q.valid;
    assign if_id_pc    = w_ifid_q.pc;
    assign if_id_instr = w_ifid_q.instr;
    assign fetch_fault = r_fetch_fault;
    assign fault_addr  = r_fault_addr;
    assign fetch_count = r_count;

endmodule
